// File: rtl/reg_writeback.sv
// Writeback stage: merges ALU and load result channels into the single register-file write port.
// Optional pending-register scoreboard is built when REG_WRITEBACK_SCOREBOARD_EN is defined.
module reg_writeback #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_alu_valid,
   output logic        o_alu_ready,
   input  logic [4:0]  i_alu_rd,
   input  logic [31:0] i_alu_data,
   input  logic        i_ld_valid,
   output logic        o_ld_ready,
   input  logic [4:0]  i_ld_rd,
   input  logic [31:0] i_ld_data,
   input  logic [2:0]  i_ld_funct3,
   input  logic [1:0]  i_ld_offset,
   input  logic        i_issue_valid,
   input  logic [4:0]  i_issue_rd,
   input  logic [4:0]  i_rs1_addr,
   input  logic [4:0]  i_rs2_addr,
   output logic        o_rs1_busy,
   output logic        o_rs2_busy,
   output logic [4:0]  o_rd_addr,
   output logic [31:0] o_rd_data,
   output logic        o_write_en
);

   localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

   logic        stall_q;
   logic [2:0]  starve_cnt;
   logic [2:0]  cnt_inc;
   logic        stall_act;
   logic        alu_acc;
   logic        ld_acc;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_ext;

   // A stall pending at reset must not hold off the ALU while reset is asserted.
   assign stall_act   = stall_q & i_rst_n;
   assign o_alu_ready = ~stall_act;
   assign o_ld_ready  = stall_act | ~i_alu_valid;
   assign alu_acc     = i_alu_valid & o_alu_ready;
   assign ld_acc      = i_ld_valid & o_ld_ready & ~alu_acc;
   assign cnt_inc     = (starve_cnt == 3'd7) ? 3'd7 : starve_cnt + 3'd1;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         stall_q    <= 1'b0;
         starve_cnt <= 3'd0;
      end else begin
         stall_q <= 1'b0;
         if (!i_ld_valid || ld_acc) begin
            starve_cnt <= 3'd0;
         end else if (cnt_inc == LIMIT) begin
            stall_q    <= 1'b1;
            starve_cnt <= 3'd0;
         end else begin
            starve_cnt <= cnt_inc;
         end
      end
   end

   always_comb begin
      ld_byte = i_ld_data[{i_ld_offset, 3'b000} +: 8];
      ld_half = i_ld_offset[1] ? i_ld_data[31:16] : i_ld_data[15:0];
      case (i_ld_funct3)
         3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_ext = {24'd0, ld_byte};
         3'b101:  ld_ext = {16'd0, ld_half};
         default: ld_ext = i_ld_data;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_write_en <= 1'b0;
         o_rd_addr  <= 5'd0;
         o_rd_data  <= 32'd0;
      end else if (alu_acc) begin
         o_write_en <= |i_alu_rd;
         o_rd_addr  <= i_alu_rd;
         o_rd_data  <= i_alu_data;
      end else if (ld_acc) begin
         o_write_en <= |i_ld_rd;
         o_rd_addr  <= i_ld_rd;
         o_rd_data  <= ld_ext;
      end else begin
         o_write_en <= 1'b0;
      end
   end

`ifdef REG_WRITEBACK_SCOREBOARD_EN
   logic [31:0] busy_q;
   logic [31:0] busy_set;
   logic [31:0] busy_clr;

   always_comb begin
      busy_set = '0;
      busy_clr = '0;
      if (i_issue_valid) busy_set[i_issue_rd] = 1'b1;
      if (o_write_en)    busy_clr[o_rd_addr]  = 1'b1;
   end

   // Set applied after clear so a re-issue in the write cycle keeps the register busy.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) busy_q <= '0;
      else          busy_q <= ((busy_q & ~busy_clr) | busy_set) & ~32'd1;
   end

   assign o_rs1_busy = busy_q[i_rs1_addr] & ~(o_write_en & (o_rd_addr == i_rs1_addr));
   assign o_rs2_busy = busy_q[i_rs2_addr] & ~(o_write_en & (o_rd_addr == i_rs2_addr));
`else
   logic unused_issue;
   assign unused_issue = ^{i_issue_valid, i_issue_rd, i_rs1_addr, i_rs2_addr};
   assign o_rs1_busy   = 1'b0;
   assign o_rs2_busy   = 1'b0;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboard bench for reg_writeback: expected writes are queued at accept and checked the next cycle.
module tb_reg_writeback;
   localparam int STARVE_LIMIT = 4;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_alu_valid, o_alu_ready;
   logic [4:0]  i_alu_rd;
   logic [31:0] i_alu_data;
   logic        i_ld_valid, o_ld_ready;
   logic [4:0]  i_ld_rd;
   logic [31:0] i_ld_data;
   logic [2:0]  i_ld_funct3;
   logic [1:0]  i_ld_offset;
   logic        i_issue_valid;
   logic [4:0]  i_issue_rd, i_rs1_addr, i_rs2_addr;
   logic        o_rs1_busy, o_rs2_busy;
   logic [4:0]  o_rd_addr;
   logic [31:0] o_rd_data;
   logic        o_write_en;

   always #5 i_clk = ~i_clk;

   reg_writeback #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_alu_valid(i_alu_valid), .o_alu_ready(o_alu_ready),
      .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data),
      .i_ld_valid(i_ld_valid), .o_ld_ready(o_ld_ready),
      .i_ld_rd(i_ld_rd), .i_ld_data(i_ld_data),
      .i_ld_funct3(i_ld_funct3), .i_ld_offset(i_ld_offset),
      .i_issue_valid(i_issue_valid), .i_issue_rd(i_issue_rd),
      .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
      .o_rs1_busy(o_rs1_busy), .o_rs2_busy(o_rs2_busy),
      .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data), .o_write_en(o_write_en)
   );

   typedef struct packed {
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_q[$];
   wr_t         m_out = '0;
   logic        m_stall = 1'b0;
   logic [2:0]  m_cnt = 3'd0;
   logic [31:0] m_busy = '0;
   logic [31:0] ld_exp = '0;
   logic        obs_ld_rdy, obs_alu_rdy;
   int          n_cmp = 0;
   int          n_err = 0;

   // {funct3, offset, expected} for raw word 0x80F0A55A
   logic [36:0] ld_tab [10] = '{
      {3'b000, 2'd3, 32'hFFFFFF80}, {3'b100, 2'd1, 32'h000000A5},
      {3'b001, 2'd2, 32'hFFFF80F0}, {3'b101, 2'd0, 32'h0000A55A},
      {3'b010, 2'd1, 32'h80F0A55A}, {3'b011, 2'd2, 32'h80F0A55A},
      {3'b000, 2'd0, 32'h0000005A}, {3'b001, 2'd3, 32'hFFFF80F0},
      {3'b100, 2'd2, 32'h000000F0}, {3'b101, 2'd3, 32'h000080F0}
   };

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   // One clock: check this cycle's outputs, model the accept, queue next cycle's write.
   task automatic cyc();
      wr_t  cur, nxt;
      logic have_cur, gated, ar, lr, alu_acc, ld_acc;
      @(negedge i_clk);
      cur      = m_out;
      have_cur = (exp_q.size() > 0);
      if (have_cur) begin
         cur = exp_q.pop_front();
         chk("write_en", o_write_en, cur.we);
         chk("rd_addr",  o_rd_addr,  cur.addr);
         chk("rd_data",  o_rd_data,  cur.data);
      end
      gated = m_stall & i_rst_n;
      ar    = ~gated;
      lr    = gated | ~i_alu_valid;
      chk("alu_ready", o_alu_ready, ar);
      chk("ld_ready",  o_ld_ready,  lr);
      obs_alu_rdy = o_alu_ready;
      obs_ld_rdy  = o_ld_ready;
      if (have_cur) begin
`ifdef REG_WRITEBACK_SCOREBOARD_EN
         chk("rs1_busy", o_rs1_busy, m_busy[i_rs1_addr] & ~(cur.we && cur.addr == i_rs1_addr));
         chk("rs2_busy", o_rs2_busy, m_busy[i_rs2_addr] & ~(cur.we && cur.addr == i_rs2_addr));
`else
         chk("rs1_busy", o_rs1_busy, 0);
         chk("rs2_busy", o_rs2_busy, 0);
`endif
      end
      alu_acc = i_rst_n & i_alu_valid & ar;
      ld_acc  = i_rst_n & i_ld_valid & lr & ~alu_acc;
      if (!i_rst_n) begin
         nxt     = '0;
         m_stall = 1'b0;
         m_cnt   = 3'd0;
         m_busy  = '0;
      end else begin
         nxt    = cur;
         nxt.we = 1'b0;
         if (alu_acc) begin
            nxt.we = (i_alu_rd != 5'd0); nxt.addr = i_alu_rd; nxt.data = i_alu_data;
         end else if (ld_acc) begin
            nxt.we = (i_ld_rd != 5'd0); nxt.addr = i_ld_rd; nxt.data = ld_exp;
         end
         if (cur.we) m_busy[cur.addr] = 1'b0;
         if (i_issue_valid) m_busy[i_issue_rd] = 1'b1;
         m_busy[0] = 1'b0;
         m_stall = 1'b0;
         if (!i_ld_valid || ld_acc) m_cnt = 3'd0;
         else begin
            if (m_cnt != 3'd7) m_cnt = m_cnt + 3'd1;
            if (m_cnt == 3'(STARVE_LIMIT)) begin
               m_stall = 1'b1;
               m_cnt   = 3'd0;
            end
         end
      end
      m_out = nxt;
      exp_q.push_back(nxt);
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle();
      i_alu_valid = 1'b0; i_ld_valid = 1'b0; i_issue_valid = 1'b0;
   endtask

   task automatic starve(input int cycles, output int wait_n);
      wait_n      = -1;
      i_alu_valid = 1'b1;
      i_ld_valid  = 1'b1;
      i_ld_rd     = 5'd12; i_ld_funct3 = 3'b010; i_ld_data = 32'hCAFE0001; ld_exp = 32'hCAFE0001;
      for (int i = 0; i < cycles; i++) begin
         i_alu_rd   = 5'(1 + i % 3);
         i_alu_data = 32'h100 + 32'(i);
         cyc();
         if (obs_ld_rdy && wait_n < 0) begin
            wait_n = i;
            chk("stall_alu_ready", obs_alu_rdy, 1'b0);
            i_ld_valid = 1'b0;
         end
      end
      i_alu_valid = 1'b0;
      i_ld_valid  = 1'b0;
   endtask

   initial begin
      int wait_n;
      i_rst_n = 1'b0; idle();
      i_alu_rd = '0; i_alu_data = '0; i_ld_rd = '0; i_ld_data = '0;
      i_ld_funct3 = '0; i_ld_offset = '0; i_issue_rd = '0; i_rs1_addr = '0; i_rs2_addr = '0;
      cyc(); cyc();
      i_rst_n = 1'b1;
      cyc();

      // ALU write rd=5
      i_alu_valid = 1'b1; i_alu_rd = 5'd5; i_alu_data = 32'h1234;
      cyc();
      idle();
      cyc();
      chk("alu_wr_data", o_rd_data, 32'h00001234);
      cyc();

      // starvation: ALU held, load waits STARVE_LIMIT cycles then wins
      starve(10, wait_n);
      chk("starve_wait", wait_n, STARVE_LIMIT);
      cyc(); cyc();

      // load extension table
      i_ld_data = 32'h80F0A55A;
      for (int i = 0; i < 10; i++) begin
         i_ld_valid = 1'b1; i_ld_rd = 5'(20 + i);
         {i_ld_funct3, i_ld_offset, ld_exp} = ld_tab[i];
         cyc();
      end
      idle(); cyc(); cyc();

      // scoreboard: issue, write, re-issue in write cycle
      i_rs1_addr = 5'd7; i_rs2_addr = 5'd3;
      i_issue_valid = 1'b1; i_issue_rd = 5'd7; cyc();
      idle(); cyc();
      i_alu_valid = 1'b1; i_alu_rd = 5'd7; i_alu_data = 32'h77; cyc();
      idle(); cyc(); cyc();
      i_issue_valid = 1'b1; i_issue_rd = 5'd7; cyc();
      idle(); i_alu_valid = 1'b1; i_alu_rd = 5'd7; i_alu_data = 32'h78; cyc();
      idle(); i_issue_valid = 1'b1; i_issue_rd = 5'd7; cyc();
      idle(); cyc(); cyc();

      // rd=0 never writes and never reads busy
      i_alu_valid = 1'b1; i_alu_rd = 5'd0; i_alu_data = 32'hDEAD; cyc();
      idle(); cyc();
      chk("rd0_we", o_write_en, 1'b0);
      i_rs1_addr = 5'd0; i_issue_valid = 1'b1; i_issue_rd = 5'd0; cyc();
      idle(); cyc();

      // reset with a pending stall and busy bits set
      i_rs1_addr = 5'd9; i_rs2_addr = 5'd7;
      i_issue_valid = 1'b1; i_issue_rd = 5'd9; cyc();
      idle();
      starve(STARVE_LIMIT, wait_n);
      i_alu_valid = 1'b1; i_ld_valid = 1'b1; i_alu_rd = 5'd2;
      i_rst_n = 1'b0; cyc();
      chk("rst_alu_ready", obs_alu_rdy, 1'b1);
      i_rst_n = 1'b1; idle(); cyc();
      chk("rst_rd_data", o_rd_data, 32'd0);
      cyc(); cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/reg_writeback.md
# reg_writeback

Writeback stage for the core: the single producer for the register file write port (`rd` address, data, write enable). It merges the one-cycle ALU result channel with the multi-cycle load-result channel, sign/zero-extends load data, and drives one registered write per cycle. It also keeps a per-register pending scoreboard that the decode stage uses for hazard stalls.

## Interface
- `STARVE_LIMIT`, default 4: consecutive denied load cycles before the ALU channel is stalled for one cycle.
- `i_clk` in 1: clock; all state updates on its rising edge.
- `i_rst_n` in 1: synchronous, active-low reset.
- `i_alu_valid` in 1: ALU result valid.
- `o_alu_ready` out 1: ALU result accepted this cycle when high together with valid.
- `i_alu_rd` in 5: ALU destination register.
- `i_alu_data` in 32: ALU result.
- `i_ld_valid` in 1: load result valid.
- `o_ld_ready` out 1: load result accepted when high together with valid.
- `i_ld_rd` in 5: load destination register.
- `i_ld_data` in 32: raw aligned memory word.
- `i_ld_funct3` in 3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `i_ld_offset` in 2: byte address bits [1:0].
- `i_issue_valid` in 1: decode issues a register-writing instruction.
- `i_issue_rd` in 5: destination register of the issued instruction.
- `i_rs1_addr`, `i_rs2_addr` in 5 each: decode source registers to check.
- `o_rs1_busy`, `o_rs2_busy` out 1 each: source has an unwritten pending producer.
- `o_rd_addr` out 5: register file write address.
- `o_rd_data` out 32: register file write data.
- `o_write_en` out 1: register file write enable.

## Operation
- Arbitration: the ALU has priority. `o_alu_ready = ~stall_q`. `o_ld_ready = stall_q | ~i_alu_valid`. At most one channel is accepted per cycle.
- Starvation counter (3-bit saturating): increments while `i_ld_valid & ~o_ld_ready`. Clears on load accept or when `i_ld_valid` is low. When the counter reaches `STARVE_LIMIT`, `stall_q` is set for exactly one cycle, then the counter clears.
- Load extension at byte offset `i_ld_offset`:
  - LB/LBU: byte `[8*off+7:8*off]`, sign-extended or zero-extended respectively.
  - LH/LHU: halfword at `off[1]`, sign-extended or zero-extended respectively; `off[0]` is ignored.
  - LW: full word; offset is ignored.
  - Undefined funct3 values are treated as LW.
- Output register: on accept, `o_rd_addr`/`o_rd_data` are loaded and `o_write_en` is set to `(rd != 0)`. With no accept, `o_write_en` is 0 and addr/data hold their values.
- Scoreboard: 32 busy bits; bit 0 is constant 0.
  - Set on `i_issue_valid` for `i_issue_rd`.
  - Cleared when `o_write_en` is high for `o_rd_addr`.
  - Set and clear of the same register in the same cycle: set wins.
- Busy query is combinational: `o_rsN_busy = busy[rsN] & ~(o_write_en & o_rd_addr == rsN)`. This matches the register file's same-cycle write forwarding.

## Timing
- Accept in cycle N gives a write at cycle N+1 (`o_write_en` high during N+1; the register file captures it at the end of N+1).
- Busy clears at the end of cycle N+1, but the query already reads 0 during N+1.
- Throughput is one write per cycle. A load waits at most `STARVE_LIMIT`+1 cycles.
- Reset (synchronous, any cycle, including mid-stall) clears:
  - `o_write_en`, `o_rd_addr`, `o_rd_data` to 0;
  - all busy bits;
  - the starvation counter and `stall_q`.
- While reset is asserted: `o_alu_ready` is 1 and `o_ld_ready` is `~i_alu_valid`, but no accept takes effect.

## Configuration
- `REG_WRITEBACK_SCOREBOARD_EN` defined: busy bits and the query logic are built as described.
- Not defined: no busy state; `o_rs1_busy`/`o_rs2_busy` are tied to 0. Decode then relies on its own stall rules.

## Test plan
- ALU valid, rd=5, data=0x1234 in cycle N -> cycle N+1: `o_write_en`=1, `o_rd_addr`=5, `o_rd_data`=0x00001234.
- ALU and load valid simultaneously with ALU valid held continuously, `STARVE_LIMIT`=4 -> load denied 4 cycles; cycle 5 has `o_alu_ready`=0 and `o_ld_ready`=1; load written next cycle.
- Load word 0x80F0A55A:
  - LB offset 3 -> 0xFFFFFF80.
  - LBU offset 1 -> 0x000000A5.
  - LH offset 2 -> 0xFFFF80F0.
  - LHU offset 0 -> 0x0000A55A.
- Issue rd=7 -> `o_rs1_busy`=1 for `rs1`=7. ALU writes rd=7 -> busy reads 0 during the write cycle, stays 0 afterward. Re-issue rd=7 in the write cycle -> busy stays 1.
- ALU write to rd=0 -> `o_write_en`=0. `o_rs1_busy` for `rs1`=0 is always 0, even after issuing rd=0.
- Reset asserted with a pending stall and busy bits set -> next cycle: all outputs 0, no busy bits, `o_alu_ready`=1.
